// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, state encoding and bit-mixing helpers.
// The schedule stage reuses the small-sigma functions from here.
package sha256_pkg;

  localparam int N      = 32;
  localparam int ROUNDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    logic [63:0] y;
    y = {x, x} >> n;
    return y[31:0];
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 round, purely combinational: working variables a..h
// (index 0..7) plus K_t and W_t in, rotated/updated a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] v_i [0:7],
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output logic [31:0] v_o [0:7]
);

  logic [31:0] t1;
  logic [31:0] t2;

  // Round function; all sums wrap modulo 2^32.
  always_comb begin
    t1 = v_i[7] + big_sigma1(v_i[4]) + ch(v_i[4], v_i[5], v_i[6]) + k_i + w_i;
    t2 = big_sigma0(v_i[0]) + maj(v_i[0], v_i[1], v_i[2]);
    v_o[0] = t1 + t2;
    v_o[1] = v_i[0];
    v_o[2] = v_i[1];
    v_o[3] = v_i[2];
    v_o[4] = v_i[3] + t1;
    v_o[5] = v_i[4];
    v_o[6] = v_i[5];
    v_o[7] = v_i[6];
  end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression stage: takes W0..W63 one per accepted beat, runs one
// round per beat, then folds a..h into the chaining hash. H persists across
// blocks so multi-block messages chain without outside help.
//
// state    | meaning
// ST_IDLE  | waiting for start_i; done_o pulses here right after ST_FINAL
// ST_ROUND | accepting schedule words, one round per accepted beat
// ST_FINAL | single cycle adding a..h into H
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int N      = 32,
  parameter int ROUNDS = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         first_blk_i,
  input  logic [N-1:0] w_i,
  input  logic         w_valid_i,
  output logic         w_ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] h_o [0:7]
);

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  state_t      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic        done_q, done_d;
  logic [31:0] v_q [0:7];
  logic [31:0] v_d [0:7];
  logic [31:0] h_q [0:7];
  logic [31:0] h_d [0:7];
  logic [31:0] v_rnd [0:7];

  sha256_round u_round (
    .v_i (v_q),
    .k_i (K[t_q]),
    .w_i (w_i),
    .v_o (v_rnd)
  );

  // Next-state, counter, working-variable and hash update.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v_d[i] = v_q[i];
      h_d[i] = h_q[i];
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ROUND;
          t_d     = '0;
          for (int i = 0; i < 8; i++) begin
            if (first_blk_i) begin
              v_d[i] = IV[i];
              h_d[i] = IV[i];
            end else begin
              v_d[i] = h_q[i];
            end
          end
        end
      end
      ST_ROUND: begin
        if (w_valid_i) begin
          for (int i = 0; i < 8; i++) v_d[i] = v_rnd[i];
          if (t_q == T_LAST) begin
            t_d     = '0;
            state_d = ST_FINAL;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end
      ST_FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, working and hash registers; reset aborts any block.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        v_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      for (int i = 0; i < 8; i++) begin
        v_q[i] <= v_d[i];
        h_q[i] <= h_d[i];
      end
    end
  end

  assign w_ready_o = (state_q == ST_ROUND);
  assign busy_o    = (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign done_o    = done_q;
  assign h_o       = h_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: a whole-message SHA-256 model
// (padding, schedule expansion, 64-round compression as plain loops) plus a
// transaction-level tracker of what the ports must show each cycle.
`timescale 1ns/1ps
module tb_sha256_compress;
  import sha256_pkg::K;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] w64_t [64];
  typedef logic [31:0] h8_t [8];

  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        first_blk_i = 1'b0;
  logic [31:0] w_i = '0;
  logic        w_valid_i = 1'b0;
  logic        w_ready_o, busy_o, done_o;
  logic [31:0] h_o [0:7];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sha256_compress dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .first_blk_i (first_blk_i),
    .w_i         (w_i),
    .w_valid_i   (w_valid_i),
    .w_ready_o   (w_ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .h_o         (h_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference SHA-256 ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} >> n;
    return y[31:0];
  endfunction

  function automatic h8_t iv_tb();
    h8_t h;
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    return h;
  endfunction

  function automatic w64_t expand(input blk_t b);
    w64_t w;
    for (int t = 0; t < 16; t++) w[t] = b[t];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    return w;
  endfunction

  function automatic h8_t compress(input h8_t hin, input w64_t w);
    logic [31:0] a, b, c, d, e, f, g, h, s1, s0, chv, mjv, x1, x2;
    h8_t r;
    a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
    e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
    for (int t = 0; t < 64; t++) begin
      s1  = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      chv = (e & f) ^ (~e & g);
      x1  = h + s1 + chv + K[t] + w[t];
      s0  = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      mjv = (a & b) ^ (a & c) ^ (b & c);
      x2  = s0 + mjv;
      h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
    end
    r[0] = hin[0] + a; r[1] = hin[1] + b; r[2] = hin[2] + c; r[3] = hin[3] + d;
    r[4] = hin[4] + e; r[5] = hin[5] + f; r[6] = hin[6] + g; r[7] = hin[7] + h;
    return r;
  endfunction

  function automatic logic [255:0] pack(input h8_t h);
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  function automatic logic [255:0] pack_o();
    return {h_o[0], h_o[1], h_o[2], h_o[3], h_o[4], h_o[5], h_o[6], h_o[7]};
  endfunction

  task automatic pad(input string s, output blk_t q[$]);
    logic [7:0] by[$];
    blk_t b;
    longint unsigned bits;
    bits = 64'(s.len()) * 8;
    q.delete();
    for (int i = 0; i < s.len(); i++) by.push_back(s[i]);
    by.push_back(8'h80);
    while (by.size() % 64 != 56) by.push_back(8'h00);
    for (int i = 7; i >= 0; i--) by.push_back(8'(bits >> (8 * i)));
    for (int j = 0; j < by.size() / 64; j++) begin
      for (int k = 0; k < 16; k++)
        b[k] = {by[j*64+4*k], by[j*64+4*k+1], by[j*64+4*k+2], by[j*64+4*k+3]};
      q.push_back(b);
    end
  endtask

  // ---------------- port-level expectation tracker ----------------
  bit          m_active = 0;
  bit          m_final  = 0;
  bit          m_done   = 0;
  h8_t         m_h      = '{default: 32'h0};
  h8_t         m_h0     = '{default: 32'h0};
  logic [31:0] wq[$];

  initial forever begin
    @(posedge clk_i or negedge rst_i);
    if (!rst_i) begin
      m_active = 0; m_final = 0; m_done = 0;
      m_h = '{default: 32'h0};
      wq.delete();
    end else begin
      m_done = 0;
      if (m_final) begin
        w64_t wb;
        for (int i = 0; i < 64; i++) wb[i] = wq[i];
        m_h     = compress(m_h0, wb);
        m_final = 0;
        m_done  = 1;
      end else if (m_active) begin
        if (w_valid_i) begin
          wq.push_back(w_i);
          if (wq.size() == 64) begin
            m_active = 0;
            m_final  = 1;
          end
        end
      end else if (start_i) begin
        if (first_blk_i) m_h = iv_tb();
        m_h0 = m_h;
        wq.delete();
        m_active = 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the tracker.
  initial forever begin
    @(negedge clk_i);
    chk("cyc_ready", 256'(w_ready_o), 256'(m_active));
    chk("cyc_busy",  256'(busy_o),    256'(m_active | m_final));
    chk("cyc_done",  256'(done_o),    256'(m_done));
    chk("cyc_hash",  pack_o(),        pack(m_h));
  end

  // Drives one block; caller must be sitting at a negedge. Returns at the
  // negedge where done_o is high so a following call starts back-to-back.
  task automatic run_block(input w64_t w, input bit first, input int stall_pct,
                           input bit illegal, input int abort_at, input bit chk_lat,
                           input string tag);
    int idx = 0, guard = 0, s_cyc, last_c = 0, c;
    bit vld, rdy, p10 = 0, p40 = 0, pulsed;
    start_i = 1'b1; first_blk_i = first; w_valid_i = 1'b1; w_i = $urandom(); s_cyc = cyc;
    @(negedge clk_i);
    start_i = 1'b0; first_blk_i = 1'($urandom_range(0, 1));
    while (idx < 64 && guard < 2000) begin
      vld = ($urandom_range(0, 99) >= 32'(stall_pct));
      w_valid_i = vld;
      w_i = vld ? w[idx] : $urandom();
      pulsed = 0;
      if (illegal && idx == 10 && !p10) begin start_i = 1'b1; first_blk_i = 1'b1; p10 = 1; pulsed = 1; end
      if (illegal && idx == 40 && !p40) begin start_i = 1'b1; first_blk_i = 1'b1; p40 = 1; pulsed = 1; end
      if (abort_at >= 0 && idx == abort_at) begin
        #2 rst_i = 1'b0;
        #1;
        chk({tag, "_rst_ready"}, 256'(w_ready_o), 256'(0));
        chk({tag, "_rst_busy"},  256'(busy_o),    256'(0));
        chk({tag, "_rst_done"},  256'(done_o),    256'(0));
        chk({tag, "_rst_hash"},  pack_o(),        256'(0));
        w_valid_i = 1'b0; start_i = 1'b0;
        return;
      end
      rdy = w_ready_o; c = cyc;
      @(negedge clk_i);
      start_i = 1'b0;
      if (pulsed) chk({tag, "_busy_after_start"}, 256'(busy_o), 256'(1));
      if (vld && rdy) begin idx++; last_c = c; end
      guard++;
    end
    if (guard >= 2000) begin
      chk({tag, "_accept_timeout"}, 256'(idx), 256'(64));
      w_valid_i = 1'b0;
      return;
    end
    chk({tag, "_ready_after_64"}, 256'(w_ready_o), 256'(0));
    w_valid_i = 1'b1; w_i = $urandom();
    for (int k = 0; k < 6 && !done_o; k++) @(negedge clk_i);
    w_valid_i = 1'b0;
    chk({tag, "_done_seen"}, 256'(done_o), 256'(1));
    chk({tag, "_last_to_done"}, 256'(cyc - last_c), 256'(2));
    if (chk_lat) chk({tag, "_start_to_done"}, 256'(cyc - s_cyc), 256'(66));
  endtask

  initial begin
    blk_t q[$];
    w64_t wa, we, w2a, w2b, wr;
    h8_t hm;
    int nd;

    #1 rst_i = 1'b0;
    #1;
    chk("reset_ready", 256'(w_ready_o), 256'(0));
    chk("reset_busy",  256'(busy_o),    256'(0));
    chk("reset_done",  256'(done_o),    256'(0));
    chk("reset_hash",  pack_o(),        256'(0));

    pad("abc", q);
    wa = expand(q[0]);
    chk("model_abc_w0",  256'(wa[0]),  256'(32'h61626380));
    chk("model_abc_w15", 256'(wa[15]), 256'(32'h00000018));
    chk("model_abc", pack(compress(iv_tb(), wa)), D_ABC);
    pad("", q);
    we = expand(q[0]);
    chk("model_empty", pack(compress(iv_tb(), we)), D_EMPTY);
    pad("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", q);
    chk("model_two_nblk", 256'(q.size()), 256'(2));
    w2a = expand(q[0]);
    w2b = expand(q[1]);
    hm = compress(compress(iv_tb(), w2a), w2b);
    chk("model_two", pack(hm), D_TWO);

    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    run_block(wa, 1, 0, 0, -1, 1, "abc");
    chk("abc_digest", pack_o(), D_ABC);
    run_block(we, 1, 0, 0, -1, 1, "empty");
    chk("empty_digest", pack_o(), D_EMPTY);
    run_block(w2a, 1, 0, 0, -1, 1, "two_a");
    run_block(w2b, 0, 0, 0, -1, 1, "two_b");
    chk("two_digest", pack_o(), D_TWO);
    repeat (3) @(negedge clk_i);
    chk("hash_holds_idle", pack_o(), D_TWO);

    run_block(wa, 1, 40, 0, -1, 0, "stall");
    chk("stall_digest", pack_o(), D_ABC);
    run_block(wa, 1, 0, 1, -1, 0, "illegal");
    chk("illegal_digest", pack_o(), D_ABC);

    run_block(wa, 1, 0, 0, 30, 0, "abort");
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    nd = 0;
    repeat (80) begin
      @(negedge clk_i);
      if (done_o) nd++;
    end
    chk("no_done_after_abort", 256'(nd), 256'(0));
    run_block(wa, 1, 0, 0, -1, 0, "fresh");
    chk("fresh_digest", pack_o(), D_ABC);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 64; i++) wr[i] = $urandom();
      run_block(wr, (n == 0) ? 1'b1 : 1'($urandom_range(0, 1)), int'($urandom_range(0, 50)),
                0, -1, 0, "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end

    @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
